// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller between the CPU data port (port 0)
// and the instruction-fetch port (port 1). One transaction at a time; address
// and write data stay frozen from issue until the arbiter is back in IDLE.
// A watchdog forces completion if the controller never answers.
// Optional build macro: SDRAM_ARB_ROUND_ROBIN_EN (alternate grants under contention).
module sdram_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 63
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic              p0_req_read,
  input  logic              p0_req_write,
  input  logic [DATA_W-1:0] p0_data_in,
  output logic [DATA_W-1:0] p0_data_out,
  output logic              p0_ack,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic              p1_req_read,
  input  logic              p1_req_write,
  input  logic [DATA_W-1:0] p1_data_in,
  output logic [DATA_W-1:0] p1_data_out,
  output logic              p1_ack,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_req_read,
  output logic              mem_req_write,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_data_valid,
  input  logic              mem_write_complete,
  output logic              timeout_flag
);

  localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, COOL} state_t;

  state_t            state;
  state_t            next_state;
  logic              grant_id;
  logic              grant_write;
  logic [WD_W-1:0]   watchdog;
  logic [WD_W-1:0]   wd_inc;
  logic              wd_expired;
  logic              comp_prev;
  logic              comp_now;
  logic              comp_edge;
  logic              p0_req;
  logic              p1_req;
  logic              any_req;
  logic              sel_port;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_address;
  logic [DATA_W-1:0] sel_data;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  logic              last_grant;
`endif

  assign p0_req  = p0_req_read | p0_req_write;
  assign p1_req  = p1_req_read | p1_req_write;
  assign any_req = p0_req | p1_req;

  // Pick the port to grant; a port asserting both read and write is served as a write
  always_comb begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    sel_port = (p0_req && p1_req) ? ~last_grant : ~p0_req;
`else
    sel_port = ~p0_req;
`endif
    sel_write   = sel_port ? p1_req_write : p0_req_write;
    sel_address = sel_port ? p1_address   : p0_address;
    sel_data    = sel_port ? p1_data_in   : p0_data_in;
  end

  // Completion is the rising edge of whichever controller level matches the operation
  always_comb begin
    comp_now  = grant_write ? mem_write_complete : mem_data_valid;
    comp_edge = comp_now & ~comp_prev;
    wd_inc    = (watchdog == '1) ? watchdog : watchdog + WD_W'(1);
  end

  // Next-state logic for the transaction sequence
  always_comb begin
    next_state = state;
    wd_expired = 1'b0;
    case (state)
      IDLE:  if (any_req) next_state = ISSUE;
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (comp_edge) begin
          next_state = DONE;
        end else if (wd_inc == WD_LIMIT) begin
          wd_expired = 1'b1;
          next_state = DONE;
        end
      end
      DONE:  next_state = COOL;
      COOL:  if (!mem_data_valid && !mem_write_complete) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register plus all registered outputs; request and ack pulses default low
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state         <= IDLE;
      grant_id      <= 1'b0;
      grant_write   <= 1'b0;
      watchdog      <= '0;
      comp_prev     <= 1'b0;
      mem_address   <= '0;
      mem_data_in   <= '0;
      mem_req_read  <= 1'b0;
      mem_req_write <= 1'b0;
      p0_data_out   <= '0;
      p1_data_out   <= '0;
      p0_ack        <= 1'b0;
      p1_ack        <= 1'b0;
      timeout_flag  <= 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      last_grant    <= 1'b1;
`endif
    end else begin
      state         <= next_state;
      comp_prev     <= comp_now;
      mem_req_read  <= 1'b0;
      mem_req_write <= 1'b0;
      p0_ack        <= 1'b0;
      p1_ack        <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id      <= sel_port;
            grant_write   <= sel_write;
            mem_address   <= sel_address;
            mem_data_in   <= sel_data;
            mem_req_write <= sel_write;
            mem_req_read  <= ~sel_write;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            last_grant    <= sel_port;
`endif
          end
        end
        ISSUE: watchdog <= '0;
        WAIT: begin
          if (comp_edge) begin
            if (!grant_write) begin
              if (grant_id) p1_data_out <= mem_data_out;
              else          p0_data_out <= mem_data_out;
            end
            p0_ack <= ~grant_id;
            p1_ack <= grant_id;
          end else begin
            watchdog <= wd_inc;
            if (wd_expired) begin
              timeout_flag <= 1'b1;
              p0_ack       <= ~grant_id;
              p1_ack       <= grant_id;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench for sdram_arbiter with a small behavioural
// SDRAM controller model (programmable latency, hold time, or never completing).
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] p0_address, p1_address, mem_address;
  logic        p0_req_read, p0_req_write, p1_req_read, p1_req_write;
  logic [31:0] p0_data_in, p1_data_in, p0_data_out, p1_data_out;
  logic        p0_ack, p1_ack;
  logic        mem_req_read, mem_req_write;
  logic [31:0] mem_data_in, mem_data_out;
  logic        mem_data_valid, mem_write_complete;
  logic        timeout_flag;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Controller model settings and monitor counters
  int          model_delay = 4;
  int          model_hold  = 1;
  bit          model_hang  = 1'b0;
  logic [31:0] model_rdata = '0;
  int          n_wr_pulse, n_rd_pulse, n_ack0, n_ack1, pulse_cyc, valid_fall_cyc, addr_glitch;
  bit          hold_check_en = 1'b0;
  logic [23:0] hold_addr = '0;

  sdram_arbiter dut (
    .CLOCK_50(clk), .rst(rst),
    .p0_address(p0_address), .p0_req_read(p0_req_read), .p0_req_write(p0_req_write),
    .p0_data_in(p0_data_in), .p0_data_out(p0_data_out), .p0_ack(p0_ack),
    .p1_address(p1_address), .p1_req_read(p1_req_read), .p1_req_write(p1_req_write),
    .p1_data_in(p1_data_in), .p1_data_out(p1_data_out), .p1_ack(p1_ack),
    .mem_address(mem_address), .mem_req_read(mem_req_read), .mem_req_write(mem_req_write),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_data_valid(mem_data_valid), .mem_write_complete(mem_write_complete),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor and controller model share one negedge process so they never race
  initial begin : model
    bit pending, active, is_wr;
    int cnt, hold;
    pending = 0; active = 0; is_wr = 0; cnt = 0; hold = 0;
    mem_data_valid = 1'b0; mem_write_complete = 1'b0; mem_data_out = '0;
    forever begin
      @(negedge clk);
      if (mem_req_write) n_wr_pulse++;
      if (mem_req_read)  n_rd_pulse++;
      if (mem_req_read || mem_req_write) pulse_cyc = cyc;
      if (p0_ack) n_ack0++;
      if (p1_ack) n_ack1++;
      if (hold_check_en && mem_address !== hold_addr) addr_glitch++;
      if (mem_req_read || mem_req_write) begin
        is_wr   = mem_req_write;
        cnt     = model_delay;
        pending = !model_hang;
      end else if (pending) begin
        cnt--;
        if (cnt <= 0) begin
          pending = 0;
          if (is_wr) mem_write_complete = 1'b1;
          else begin
            mem_data_out   = model_rdata;
            mem_data_valid = 1'b1;
          end
          hold   = model_hold;
          active = 1;
        end
      end else if (active) begin
        hold--;
        if (hold <= 0) begin
          active             = 0;
          mem_write_complete = 1'b0;
          mem_data_valid     = 1'b0;
          valid_fall_cyc     = cyc;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input bit rd, input bit wr,
                               input logic [23:0] addr, input logic [31:0] data);
    if (port == 0) begin
      p0_req_read = rd; p0_req_write = wr; p0_address = addr; p0_data_in = data;
    end else begin
      p1_req_read = rd; p1_req_write = wr; p1_address = addr; p1_data_in = data;
    end
  endtask

  task automatic resetCounters();
    n_wr_pulse = 0; n_rd_pulse = 0; n_ack0 = 0; n_ack1 = 0;
    pulse_cyc = 0; addr_glitch = 0;
  endtask

  task automatic waitAck(input int port, input int limit, output bit seen, output int ack_at);
    seen = 0; ack_at = 0;
    for (int i = 0; i < limit; i++) begin
      tick(1);
      if ((port == 0 && p0_ack) || (port == 1 && p1_ack)) begin
        seen = 1; ack_at = cyc;
        return;
      end
    end
  endtask

  task automatic waitPulse(input int limit, output bit seen);
    seen = 0;
    for (int i = 0; i < limit; i++) begin
      tick(1);
      if (n_wr_pulse + n_rd_pulse > 0) begin
        seen = 1;
        return;
      end
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: bench did not finish");
    $fatal(1, "[TB] simulation time limit hit");
  end

  initial begin
    bit seen;
    int ack_at, lat, got;
    int seq [4];
    int exp_seq [4];
    rst = 1'b1;
    applyStimulus(0, 0, 0, '0, '0);
    applyStimulus(1, 0, 0, '0, '0);
    resetCounters();
    tick(3);

    // Reset values
    checkOutput("rst_p0_ack", p0_ack, 0);
    checkOutput("rst_p1_ack", p1_ack, 0);
    checkOutput("rst_mem_req", {mem_req_read, mem_req_write}, 0);
    checkOutput("rst_timeout", timeout_flag, 0);
    checkOutput("rst_mem_addr", mem_address, 0);
    checkOutput("rst_p0_dout", p0_data_out, 0);
    rst = 1'b0;
    tick(2);

    // Port 0 write, completion 10 cycles after the pulse
    resetCounters();
    model_delay = 10; model_hold = 1; model_hang = 0;
    applyStimulus(0, 0, 1, 24'h000123, 32'hDEADBEEF);
    waitPulse(20, seen);
    checkOutput("wr_pulse_seen", seen, 1);
    hold_addr = 24'h000123; hold_check_en = 1'b1;
    waitAck(0, 100, seen, ack_at);
    applyStimulus(0, 0, 0, '0, '0);
    checkOutput("wr_ack_seen", seen, 1);
    lat = ack_at - pulse_cyc;
    checkOutput("wr_latency_ok", (lat >= 11 && lat <= 13), 1);
    checkOutput("wr_mem_data_in", mem_data_in, 32'hDEADBEEF);
    tick(4);
    hold_check_en = 1'b0;
    checkOutput("wr_addr_stable", addr_glitch, 0);
    checkOutput("wr_pulses", n_wr_pulse, 1);
    checkOutput("wr_no_read", n_rd_pulse, 0);
    checkOutput("wr_p0_acks", n_ack0, 1);
    checkOutput("wr_p1_acks", n_ack1, 0);

    // Port 1 read with data_valid held two cycles
    resetCounters();
    model_delay = 5; model_hold = 2; model_rdata = 32'h12345678;
    applyStimulus(1, 1, 0, 24'h00ABCD, '0);
    waitAck(1, 100, seen, ack_at);
    applyStimulus(1, 0, 0, '0, '0);
    checkOutput("rd_ack_seen", seen, 1);
    checkOutput("rd_p1_dout", p1_data_out, 32'h12345678);
    tick(10);
    checkOutput("rd_pulses", n_rd_pulse, 1);
    checkOutput("rd_p1_acks", n_ack1, 1);
    checkOutput("rd_p0_acks", n_ack0, 0);
    checkOutput("rd_p0_dout_kept", p0_data_out, 0);

    // Both ports hold read requests for four rounds
    resetCounters();
    model_delay = 3; model_hold = 1; model_rdata = 32'hA5A50001;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    seq = '{-1, -1, -1, -1};
    got = 0;
    applyStimulus(0, 1, 0, 24'h000010, '0);
    applyStimulus(1, 1, 0, 24'h000020, '0);
    for (int i = 0; i < 400 && got < 4; i++) begin
      tick(1);
      if (p0_ack) begin seq[got] = 0; got++; end
      else if (p1_ack) begin seq[got] = 1; got++; end
    end
    applyStimulus(0, 0, 0, '0, '0);
    applyStimulus(1, 0, 0, '0, '0);
    checkOutput("arb_rounds", got, 4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("arb_grant%0d", i), seq[i], exp_seq[i]);
    checkOutput("arb_p0_dout", p0_data_out, 32'hA5A50001);
    tick(6);

    // Controller never completes: watchdog forces the ack
    resetCounters();
    model_hang = 1;
    applyStimulus(0, 1, 0, 24'h000055, '0);
    waitAck(0, 200, seen, ack_at);
    applyStimulus(0, 0, 0, '0, '0);
    checkOutput("to_ack_seen", seen, 1);
    lat = ack_at - pulse_cyc;
    checkOutput("to_latency_ok", (lat >= 64 && lat <= 66), 1);
    checkOutput("to_flag", timeout_flag, 1);
    checkOutput("to_p0_dout_kept", p0_data_out, 32'hA5A50001);
    tick(3);
    resetCounters();
    model_hang = 0; model_delay = 4; model_hold = 1;
    applyStimulus(1, 0, 1, 24'h000066, 32'h11112222);
    waitAck(1, 100, seen, ack_at);
    applyStimulus(1, 0, 0, '0, '0);
    checkOutput("to_next_ack", seen, 1);
    checkOutput("to_next_wdata", mem_data_in, 32'h11112222);
    checkOutput("to_flag_sticky", timeout_flag, 1);
    tick(4);
    checkOutput("to_next_pulses", n_wr_pulse, 1);

    // Reset while waiting on a hung controller
    resetCounters();
    model_hang = 1;
    applyStimulus(0, 0, 1, 24'h000200, 32'h00000033);
    waitPulse(20, seen);
    checkOutput("rw_pulse_seen", seen, 1);
    tick(5);
    rst = 1'b1;
    applyStimulus(0, 0, 0, '0, '0);
    tick(1);
    checkOutput("rw_acks", {p0_ack, p1_ack}, 0);
    checkOutput("rw_mem_req", {mem_req_read, mem_req_write}, 0);
    checkOutput("rw_timeout_clr", timeout_flag, 0);
    checkOutput("rw_mem_addr", mem_address, 0);
    rst = 1'b0;
    tick(3);
    checkOutput("rw_no_ack", n_ack0 + n_ack1, 0);
    resetCounters();
    model_hang = 0; model_delay = 4; model_rdata = 32'hCAFEF00D;
    applyStimulus(1, 1, 0, 24'h000077, '0);
    waitAck(1, 100, seen, ack_at);
    applyStimulus(1, 0, 0, '0, '0);
    checkOutput("rw_new_ack", seen, 1);
    checkOutput("rw_new_dout", p1_data_out, 32'hCAFEF00D);
    checkOutput("rw_new_addr", mem_address, 24'h000077);
    checkOutput("rw_new_pulses", n_rd_pulse, 1);
    tick(4);

    // Long data_valid: arbiter must sit in COOL until the level falls
    resetCounters();
    model_delay = 2; model_hold = 6; model_rdata = 32'h0BADCAFE;
    valid_fall_cyc = 0;
    applyStimulus(0, 1, 0, 24'h000099, '0);
    waitAck(0, 100, seen, ack_at);
    applyStimulus(0, 0, 0, '0, '0);
    checkOutput("cool_ack_seen", seen, 1);
    checkOutput("cool_p0_dout", p0_data_out, 32'h0BADCAFE);
    model_hold = 1; model_rdata = 32'h600D0001;
    applyStimulus(1, 1, 0, 24'h0000AA, '0);
    waitAck(1, 100, seen, ack_at);
    applyStimulus(1, 0, 0, '0, '0);
    checkOutput("cool_next_ack", seen, 1);
    checkOutput("cool_issue_after_fall", (valid_fall_cyc > 0 && pulse_cyc > valid_fall_cyc), 1);
    checkOutput("cool_p1_dout", p1_data_out, 32'h600D0001);
    tick(6);
    checkOutput("cool_pulses", n_rd_pulse, 2);
    checkOutput("cool_p0_acks", n_ack0, 1);
    checkOutput("cool_p1_acks", n_ack1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
